rv32i_instr_writer: RTL and testbench
=====================================

Name: rv32i_instr_writer

Overview:
- Inverse of the instruction-register field decode: accepts RV32I instruction fields (opcode, funct3, funct7, register indices, full 32-bit immediate) over a valid/ready handshake.
- Packs the fields into a 32-bit instruction word, checks that the immediate is encodable, and writes legal words to memory at a self-incrementing word address.
- Used by the self-loading test harness and the boot-time program loader to place generated code in front of the mp2 datapath's memory port.

Parameters:
- BASE_ADDR, 32'h0000_0060, write address after reset; bits [1:0] must be 0.
- CNT_W, 16, width of the written-word and rejected-word counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  field bundle valid
- in_ready  out  1  block accepts bundle this cycle
- opcode  in  7  RV32I opcode
- funct3  in  3  funct3
- funct7  in  7  funct7; used only by R-type and shift-immediate
- rs1, rs2, rd  in  5 each  register indices
- imm  in  32  signed byte-offset / value immediate
- addr_load  in  1  load write address from addr_in
- addr_in  in  32  new write address; bits [1:0] ignored
- mem_address  out  32  word-aligned write address
- mem_wdata  out  32  encoded instruction
- mem_byte_enable  out  4  always 4'hF while mem_write = 1, else 4'h0
- mem_write  out  1  write request
- mem_resp  in  1  memory done
- err  out  1  sticky: any bundle rejected since reset
- wr_count  out  CNT_W  words written
- rej_count  out  CNT_W  bundles rejected

Behaviour:
- Reset: state IDLE, write address = BASE_ADDR, mem_write = 0, mem_wdata = 0, err = 0, both counters = 0.
- Outputs during reset: mem_address = BASE_ADDR, in_ready = 0.
- FSM states: IDLE, WRITE.
- in_ready = 1 only in IDLE with addr_load = 0.
- IDLE, in_valid & in_ready: encode combinationally and register the word into mem_wdata.
  - Legal word -> go to WRITE.
  - Illegal word -> stay IDLE, err <= 1, rej_count++, word dropped, mem_wdata unchanged.
- WRITE: mem_write = 1, mem_address and mem_wdata held stable until mem_resp.
  - On mem_resp: address += 4 (wraps modulo 2^32), wr_count++, go to IDLE.
  - mem_resp in the first WRITE cycle is legal. Minimum is 2 cycles per word (accept + write).
  - mem_resp outside WRITE is ignored.
- addr_load in IDLE: address <= {addr_in[31:2], 2'b00}. It has priority over acceptance, and no bundle is taken that cycle. addr_load in WRITE is ignored.
- Counters saturate at all-ones.
- Encoding by opcode (fixed bits: [6:0] = opcode on all formats; rd in [11:7], funct3 in [14:12], rs1 in [19:15] where the format has them):
  - R 0110011: funct7 [31:25], rs2 [24:20], rs1, funct3, rd.
  - I 0010011 / 0000011 / 1100111 / 1110011: imm[11:0] [31:20], rs1, funct3, rd.
    - Legal only if imm fits signed 12 bits.
    - Shift-immediate exception (0010011 with funct3 001/101): [31:25] = funct7, [24:20] = imm[4:0]. Legal only if imm[31:5] = 0.
  - S 0100011: imm[11:5] [31:25], rs2, rs1, funct3, imm[4:0] [11:7]. Legal only if imm fits signed 12 bits.
  - B 1100011: imm[12] [31], imm[10:5] [30:25], rs2, rs1, funct3, imm[4:1] [11:8], imm[11] [7].
    - Legal only if imm fits signed 13 bits and imm[0] = 0.
  - U 0110111 / 0010111: imm[31:12] [31:12], rd. Legal only if imm[11:0] = 0.
  - J 1101111: imm[20] [31], imm[10:1] [30:21], imm[11] [20], imm[19:12] [19:12], rd.
    - Legal only if imm fits signed 21 bits and imm[0] = 0.
  - Any other opcode: illegal.
- "Fits signed N bits" means imm[31:N-1] is all zeros or all ones.
- Reset mid-WRITE: the request is abandoned immediately (mem_write = 0 in the next cycle) and all state returns to reset values.

Test Plan:
- Reset, then addi x1,x0,5 (opcode 0010011, f3 000, rd 1, rs1 0, imm 5); mem_resp after 3 cycles.
  - Required: mem_wdata = 0x00500093 at 0x60, held for all 3 cycles, then address 0x64 and wr_count = 1.
- sw x2,8(x1) -> 0x0020A423; beq x0,x0,imm = -4 -> 0xFE000EE3; lui x5,imm = 0x12345000 -> 0x123452B7.
  - Required: written at consecutive addresses with mem_resp returned in the first WRITE cycle.
- jal rd 1, imm = 1; then addi imm = 2048; then opcode 0000000.
  - Required: each rejected; in_ready stays 1, no mem_write, err = 1, rej_count = 3, address unchanged.
- slli x3,x3,31 (f3 001, funct7 0, imm 31) -> 0x01F19193 accepted.
  - Required: slli with imm 32 is rejected.
- addr_load with addr_in = 0xFFFF_FFFF together with in_valid.
  - Required: address = 0xFFFF_FFFC, bundle not accepted that cycle. The next word is written at 0xFFFF_FFFC and the address then wraps to 0x0000_0000.
- addr_load pulsed during WRITE; then rst during a WRITE with no mem_resp.
  - Required: addr_load is ignored. After rst, mem_write = 0 the next cycle, address = 0x60, counters = 0, err = 0.

Source files
------------

// File: rtl/rv32i_instr_writer_if.sv
// rtl/rv32i_instr_writer_if.sv - field bundle, address load and memory write port of the instruction writer
interface rv32i_instr_writer_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [31:0]      imm;
    logic             addr_load;
    logic [31:0]      addr_in;
    logic [31:0]      mem_address;
    logic [31:0]      mem_wdata;
    logic [3:0]       mem_byte_enable;
    logic             mem_write;
    logic             mem_resp;
    logic             err;
    logic [CNT_W-1:0] wr_count;
    logic [CNT_W-1:0] rej_count;

    // Writer side: consumes field bundles, drives the memory write port
    modport master (
        input  in_valid, opcode, funct3, funct7, rs1, rs2, rd, imm,
        input  addr_load, addr_in, mem_resp,
        output in_ready, mem_address, mem_wdata, mem_byte_enable, mem_write,
        output err, wr_count, rej_count
    );

    // Harness side: produces field bundles, answers memory writes
    modport slave (
        output in_valid, opcode, funct3, funct7, rs1, rs2, rd, imm,
        output addr_load, addr_in, mem_resp,
        input  in_ready, mem_address, mem_wdata, mem_byte_enable, mem_write,
        input  err, wr_count, rej_count
    );
endinterface

// File: rtl/rv32i_instr_writer.sv
// rtl/rv32i_instr_writer.sv - packs RV32I fields into instruction words and writes them to sequential memory words
module rv32i_instr_writer #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0060,
    parameter int          CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    rv32i_instr_writer_if.master bus
);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_WRITE = 1'b1;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic [0:0]       r_state;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             r_err;
    logic [CNT_W-1:0] r_wr_count;
    logic [CNT_W-1:0] r_rej_count;

    logic [31:0]      w_word;
    logic             w_legal;
    logic             w_in_ready;
    logic             w_mem_write;
    logic [31:0]      w_addr_aligned;

    // True when the value sign-extends from its low n bits, i.e. v[31:n-1] is all zeros or all ones
    function automatic logic fits_signed(input logic [31:0] v, input int n);
        logic [31:0] s;
        s = $signed(v) >>> (n - 1);
        return (s == 32'h0000_0000) || (s == 32'hFFFF_FFFF);
    endfunction

    assign w_addr_aligned = bus.addr_in & 32'hFFFF_FFFC;

    // Pack the fields for the format selected by the opcode and judge whether the immediate is encodable
    always_comb begin
        w_word  = 32'h0;
        w_legal = 1'b0;
        case (bus.opcode)
            OP_R: begin
                w_word  = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
                w_legal = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
                if ((bus.opcode == OP_IMM) && (bus.funct3[1:0] == 2'b01)) begin
                    // slli/srli/srai: shamt sits in the low immediate bits, funct7 selects the shift kind
                    w_word  = {bus.funct7, bus.imm[4:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
                    w_legal = (bus.imm[31:5] == 27'h0);
                end else begin
                    w_word  = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
                    w_legal = fits_signed(bus.imm, 12);
                end
            end
            OP_STORE: begin
                w_word  = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
                w_legal = fits_signed(bus.imm, 12);
            end
            OP_BRANCH: begin
                w_word  = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                           bus.imm[4:1], bus.imm[11], bus.opcode};
                w_legal = fits_signed(bus.imm, 13) && !bus.imm[0];
            end
            OP_LUI, OP_AUIPC: begin
                w_word  = {bus.imm[31:12], bus.rd, bus.opcode};
                w_legal = (bus.imm[11:0] == 12'h0);
            end
            OP_JAL: begin
                w_word  = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, bus.opcode};
                w_legal = fits_signed(bus.imm, 21) && !bus.imm[0];
            end
            default: begin
                w_word  = 32'h0;
                w_legal = 1'b0;
            end
        endcase
    end

    // Handshake and write-port outputs; reset forces the idle/base view immediately
    always_comb begin
        w_in_ready  = !rst && (r_state == S_IDLE) && !bus.addr_load;
        w_mem_write = !rst && (r_state == S_WRITE);
    end

    assign bus.in_ready        = w_in_ready;
    assign bus.mem_write       = w_mem_write;
    assign bus.mem_byte_enable = w_mem_write ? 4'hF : 4'h0;
    assign bus.mem_address     = rst ? BASE_ADDR : r_addr;
    assign bus.mem_wdata       = r_wdata;
    assign bus.err             = r_err;
    assign bus.wr_count        = r_wr_count;
    assign bus.rej_count       = r_rej_count;

    // Accept/reject bundles, hold the write until the memory answers, then advance the address
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= BASE_ADDR;
            r_wdata     <= 32'h0;
            r_err       <= 1'b0;
            r_wr_count  <= '0;
            r_rej_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.addr_load) begin
                        r_addr <= w_addr_aligned;
                    end else if (bus.in_valid) begin
                        if (w_legal) begin
                            r_wdata <= w_word;
                            r_state <= S_WRITE;
                        end else begin
                            r_err <= 1'b1;
                            if (r_rej_count != '1) begin
                                r_rej_count <= r_rej_count + 1'b1;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.mem_resp) begin
                        r_addr  <= r_addr + 32'd4;
                        r_state <= S_IDLE;
                        if (r_wr_count != '1) begin
                            r_wr_count <= r_wr_count + 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_instr_writer.sv
// tb/tb_rv32i_instr_writer.sv - directed-vector bench for the RV32I instruction writer
module tb_rv32i_instr_writer;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    rv32i_instr_writer_if #(.CNT_W(16)) bus ();

    rv32i_instr_writer #(
        .BASE_ADDR (32'h0000_0060),
        .CNT_W     (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_passed = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                         input logic [31:0] im);
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.funct7   = f7;
        bus.rs1      = s1;
        bus.rs2      = s2;
        bus.rd       = d;
        bus.imm      = im;
        bus.in_valid = 1'b1;
    endtask

    task automatic write_word(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                              input logic [31:0] im, input logic [31:0] exp_word,
                              input logic [31:0] exp_addr, input int nresp);
        @(negedge clk);
        drive(op, f3, f7, s1, s2, d, im);
        #1;
        check_val("accept_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 1; i <= nresp; i++) begin
            #1;
            check_val("wr_mem_write", 32'(bus.mem_write), 32'd1);
            check_val("wr_address", bus.mem_address, exp_addr);
            check_val("wr_wdata", bus.mem_wdata, exp_word);
            check_val("wr_byte_en", 32'(bus.mem_byte_enable), 32'hF);
            bus.mem_resp = (i == nresp);
            @(negedge clk);
        end
        bus.mem_resp = 1'b0;
        #1;
        check_val("post_mem_write", 32'(bus.mem_write), 32'd0);
        check_val("post_byte_en", 32'(bus.mem_byte_enable), 32'h0);
        check_val("post_address", bus.mem_address, exp_addr + 32'd4);
    endtask

    task automatic reject_word(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                               input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                               input logic [31:0] im, input logic [31:0] exp_addr);
        @(negedge clk);
        drive(op, f3, f7, s1, s2, d, im);
        #1;
        check_val("rej_ready_before", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check_val("rej_mem_write", 32'(bus.mem_write), 32'd0);
        check_val("rej_ready_after", 32'(bus.in_ready), 32'd1);
        check_val("rej_address", bus.mem_address, exp_addr);
        check_val("rej_err", 32'(bus.err), 32'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.addr_load = 1'b0;
        bus.addr_in   = 32'h0;
        bus.mem_resp  = 1'b0;
        drive(7'h0, 3'h0, 7'h0, 5'h0, 5'h0, 5'h0, 32'h0);
        bus.in_valid  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check_val("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check_val("rst_address", bus.mem_address, 32'h60);
        check_val("rst_mem_write", 32'(bus.mem_write), 32'd0);
        check_val("rst_wdata", bus.mem_wdata, 32'h0);
        check_val("rst_err", 32'(bus.err), 32'd0);
        check_val("rst_wr_count", 32'(bus.wr_count), 32'd0);
        check_val("rst_rej_count", 32'(bus.rej_count), 32'd0);
        rst = 1'b0;

        // addi x1,x0,5 with a 3-cycle memory response
        write_word(7'b0010011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 32'd5, 32'h0050_0093, 32'h60, 3);
        check_val("addi_wr_count", 32'(bus.wr_count), 32'd1);

        // sw / beq / lui answered in the first WRITE cycle
        write_word(7'b0100011, 3'b010, 7'h00, 5'd1, 5'd2, 5'd0, 32'd8, 32'h0020_A423, 32'h64, 1);
        write_word(7'b1100011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFE00_0EE3, 32'h68, 1);
        write_word(7'b0110111, 3'b000, 7'h00, 5'd0, 5'd0, 5'd5, 32'h1234_5000, 32'h1234_52B7, 32'h6C, 1);
        check_val("seq_wr_count", 32'(bus.wr_count), 32'd4);

        // A stray mem_resp while idle changes nothing
        @(negedge clk);
        bus.mem_resp = 1'b1;
        @(negedge clk);
        bus.mem_resp = 1'b0;
        #1;
        check_val("idle_resp_wr_count", 32'(bus.wr_count), 32'd4);
        check_val("idle_resp_address", bus.mem_address, 32'h70);

        // Unencodable bundles: odd jal offset, out-of-range addi, unknown opcode
        reject_word(7'b1101111, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 32'd1, 32'h70);
        reject_word(7'b0010011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 32'd2048, 32'h70);
        reject_word(7'b0000000, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 32'd0, 32'h70);
        check_val("rej_count_3", 32'(bus.rej_count), 32'd3);
        check_val("rej_wdata_kept", bus.mem_wdata, 32'h1234_52B7);
        check_val("rej_wr_count", 32'(bus.wr_count), 32'd4);

        // Shift-immediate: shamt 31 encodes, 32 does not
        write_word(7'b0010011, 3'b001, 7'h00, 5'd3, 5'd0, 5'd3, 32'd31, 32'h01F1_9193, 32'h70, 1);
        reject_word(7'b0010011, 3'b001, 7'h00, 5'd3, 5'd0, 5'd3, 32'd32, 32'h74);
        check_val("slli_rej_count", 32'(bus.rej_count), 32'd4);

        // R-type add/sub and a legal jal
        write_word(7'b0110011, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0020_81B3, 32'h74, 2);
        write_word(7'b0110011, 3'b000, 7'h20, 5'd1, 5'd2, 5'd3, 32'h0, 32'h4020_81B3, 32'h78, 1);
        write_word(7'b1101111, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 32'd8, 32'h0080_00EF, 32'h7C, 1);
        check_val("r_j_wr_count", 32'(bus.wr_count), 32'd8);

        // addr_load beats a simultaneous bundle; the next write wraps the address
        @(negedge clk);
        bus.addr_load = 1'b1;
        bus.addr_in   = 32'hFFFF_FFFF;
        drive(7'b0110011, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0);
        #1;
        check_val("ld_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        bus.addr_load = 1'b0;
        bus.in_valid  = 1'b0;
        #1;
        check_val("ld_mem_write", 32'(bus.mem_write), 32'd0);
        check_val("ld_address", bus.mem_address, 32'hFFFF_FFFC);
        check_val("ld_wr_count", 32'(bus.wr_count), 32'd8);
        write_word(7'b0110011, 3'b000, 7'h00, 5'd1, 5'd2, 5'd3, 32'h0, 32'h0020_81B3, 32'hFFFF_FFFC, 1);
        check_val("wrap_address", bus.mem_address, 32'h0);
        check_val("wrap_wr_count", 32'(bus.wr_count), 32'd9);

        // addr_load during WRITE is ignored; reset abandons the pending write
        @(negedge clk);
        drive(7'b0010011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 32'd5);
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.addr_load = 1'b1;
        bus.addr_in   = 32'h0000_1000;
        #1;
        check_val("wl_mem_write", 32'(bus.mem_write), 32'd1);
        check_val("wl_address", bus.mem_address, 32'h0);
        @(negedge clk);
        bus.addr_load = 1'b0;
        #1;
        check_val("wl_held_write", 32'(bus.mem_write), 32'd1);
        check_val("wl_held_address", bus.mem_address, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check_val("mrst_mem_write", 32'(bus.mem_write), 32'd0);
        check_val("mrst_address", bus.mem_address, 32'h60);
        check_val("mrst_wr_count", 32'(bus.wr_count), 32'd0);
        check_val("mrst_rej_count", 32'(bus.rej_count), 32'd0);
        check_val("mrst_err", 32'(bus.err), 32'd0);
        check_val("mrst_wdata", bus.mem_wdata, 32'h0);
        rst = 1'b0;
        #1;
        check_val("mrst_in_ready", 32'(bus.in_ready), 32'd1);

        // Normal operation resumes from the base address
        write_word(7'b0010011, 3'b000, 7'h00, 5'd0, 5'd0, 5'd1, 32'd5, 32'h0050_0093, 32'h60, 1);
        check_val("resume_wr_count", 32'(bus.wr_count), 32'd1);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
